// File: rtl/prbs_checker.sv
// Receive-side PRBS checker for the 4-level symbol chain.
// Regenerates the b[n] = b[n-21] ^ b[n-22] sequence from the sliced symbols,
// locks to it through SEEK -> VERIFY -> LOCKED, flags each locked symbol as
// correct or in error, and accumulates windowed error counts for BER.
module prbs_checker #(
  parameter int VERIFY_LEN  = 16,
  parameter int LOSS_THRESH = 8,
  parameter int WINDOW      = 4194303,
  parameter int ERR_W       = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_clk_ena,
  input  logic             clear_counts,
  input  logic [1:0]       slice_in,
  output logic [1:0]       state,
  output logic             locked,
  output logic             sym_correct,
  output logic             sym_error,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] window_err,
  output logic             window_valid
);

  localparam int MW = $clog2(VERIFY_LEN + 1);
  localparam int CW = $clog2(LOSS_THRESH + 1);
  localparam int SW = $clog2(WINDOW + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  // 11 symbols = 22 bits, exactly one full history fill
  localparam logic [3:0] FILL_LAST = 4'd10;

  typedef enum logic [1:0] {SEEK = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} st_e;

  st_e              st_q, st_d;
  logic [21:0]      hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CW-1:0]    consec_q, consec_d;
  logic [SW-1:0]    symcnt_q, symcnt_d;
  logic [ERR_W-1:0] err_q, err_d, werr_q, werr_d;
  logic             corr_q, corr_d, erro_q, erro_d, wvld_q, wvld_d;

  logic [1:0]       pred;
  logic             mis;
  logic [ERR_W-1:0] err_add;

  // Predicted symbol from history alone; both bits are already determined
  assign pred    = {hist_q[20] ^ hist_q[21], hist_q[19] ^ hist_q[20]};
  assign mis     = (slice_in != pred);
  assign err_add = (mis && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;

  // Next-state and next-output logic for the lock FSM and counters
  always_comb begin
    st_d     = st_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    consec_d = consec_q;
    symcnt_d = symcnt_q;
    err_d    = err_q;
    werr_d   = werr_q;
    corr_d   = 1'b0;
    erro_d   = 1'b0;
    wvld_d   = 1'b0;
    if (sym_clk_ena) begin
      unique case (st_q)
        SEEK: begin
          hist_d = {hist_q[19:0], slice_in};
          if (fill_q == FILL_LAST) begin
            st_d    = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        VERIFY: begin
          hist_d = {hist_q[19:0], pred};
          if (mis) begin
            st_d   = SEEK;
            fill_d = '0;
          end else if (match_q == MW'(VERIFY_LEN - 1)) begin
            st_d     = LOCKED;
            consec_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end
        LOCKED: begin
          // Flywheel on predictions so a bad symbol never enters the history
          hist_d = {hist_q[19:0], pred};
          corr_d = ~mis;
          erro_d = mis;
          err_d  = err_add;
          if (!mis) begin
            consec_d = '0;
          end else if (consec_q == CW'(LOSS_THRESH - 1)) begin
            st_d     = SEEK;
            fill_d   = '0;
            consec_d = '0;
          end else begin
            consec_d = consec_q + CW'(1);
          end
          if (symcnt_q == SW'(WINDOW - 1)) begin
            werr_d   = err_add;
            wvld_d   = 1'b1;
            err_d    = '0;
            symcnt_d = '0;
          end else begin
            symcnt_d = symcnt_q + SW'(1);
          end
        end
        default: st_d = SEEK;
      endcase
      // Clear wins over a coincident window end and leaves state/history alone
      if (clear_counts) begin
        err_d    = '0;
        symcnt_d = '0;
        consec_d = '0;
        werr_d   = werr_q;
        wvld_d   = 1'b0;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= SEEK;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      consec_q <= '0;
      symcnt_q <= '0;
      err_q    <= '0;
      werr_q   <= '0;
      corr_q   <= 1'b0;
      erro_q   <= 1'b0;
      wvld_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      consec_q <= consec_d;
      symcnt_q <= symcnt_d;
      err_q    <= err_d;
      werr_q   <= werr_d;
      corr_q   <= corr_d;
      erro_q   <= erro_d;
      wvld_q   <= wvld_d;
    end
  end

  assign state        = st_q;
  assign locked       = (st_q == LOCKED);
  assign sym_correct  = corr_q;
  assign sym_error    = erro_q;
  assign err_count    = err_q;
  assign window_err   = werr_q;
  assign window_valid = wvld_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two configurations share one stimulus stream and
// are checked against a bit-level behavioural model every step.
module tb_prbs_checker;

  logic        clk, reset_n, sym_clk_ena, clear_counts;
  logic [1:0]  slice_in;
  logic [1:0]  state_a, state_b;
  logic        locked_a, locked_b, corr_a, corr_b, erro_a, erro_b, wv_a, wv_b;
  logic [23:0] err_a, werr_a;
  logic [3:0]  err_b, werr_b;

  prbs_checker #(.WINDOW(100)) u_a (
    .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena), .clear_counts(clear_counts),
    .slice_in(slice_in), .state(state_a), .locked(locked_a), .sym_correct(corr_a),
    .sym_error(erro_a), .err_count(err_a), .window_err(werr_a), .window_valid(wv_a));

  prbs_checker #(.WINDOW(100), .ERR_W(4), .LOSS_THRESH(255)) u_b (
    .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena), .clear_counts(clear_counts),
    .slice_in(slice_in), .state(state_b), .locked(locked_b), .sym_correct(corr_b),
    .sym_error(erro_b), .err_count(err_b), .window_err(werr_b), .window_valid(wv_b));

  always #5 clk = ~clk;

  typedef struct {
    int st, fill, match, consec, symcnt;
    longint err, werr;
    bit corr, erro, wv;
    bit [21:0] h;   // h[k] = bit received k+1 bits ago
  } mdl_t;

  mdl_t ma, mb;
  bit [21:0] tx;
  int total, bad;

  function automatic mdl_t mdl_zero();
    mdl_t m;
    m.st = 0; m.fill = 0; m.match = 0; m.consec = 0; m.symcnt = 0;
    m.err = 0; m.werr = 0; m.corr = 0; m.erro = 0; m.wv = 0; m.h = '0;
    return m;
  endfunction

  // One enabled symbol through the checker behaviour, from the rule text
  task automatic mdl_step(inout mdl_t m, input int vl, input int lt, input int win,
                          input int ew, input bit clr, input bit [1:0] s);
    longint mx = (longint'(1) << ew) - 1;
    longint old_werr = m.werr;
    longint e_add;
    bit [21:0] t = m.h;
    bit [1:0] p;
    bit miss;
    // extend the recurrence by two bits to get the expected symbol
    p[1] = t[20] ^ t[21]; t = {t[20:0], p[1]};
    p[0] = t[20] ^ t[21];
    miss = (s != p);
    e_add = (miss && m.err < mx) ? m.err + 1 : m.err;
    m.corr = 0; m.erro = 0; m.wv = 0;
    if (m.st == 0) begin
      m.h = {m.h[19:0], s};
      m.fill++;
      if (m.fill == 11) begin m.st = 1; m.fill = 0; m.match = 0; end
    end else if (m.st == 1) begin
      m.h = {m.h[19:0], p};
      if (miss) begin m.st = 0; m.fill = 0; end
      else begin
        m.match++;
        if (m.match == vl) begin m.st = 2; m.consec = 0; end
      end
    end else begin
      m.h = {m.h[19:0], p};
      m.corr = !miss; m.erro = miss;
      m.consec = miss ? m.consec + 1 : 0;
      if (m.consec == lt) begin m.st = 0; m.fill = 0; m.consec = 0; end
      m.symcnt++;
      if (m.symcnt == win) begin
        m.werr = e_add; m.wv = 1; m.err = 0; m.symcnt = 0;
      end else m.err = e_add;
    end
    if (clr) begin m.err = 0; m.symcnt = 0; m.consec = 0; m.wv = 0; m.werr = old_werr; end
  endtask

  function automatic logic [53:0] exp_v(input mdl_t m);
    logic [63:0] e = m.err, w = m.werr;
    return {2'(m.st), 1'(m.st == 2), m.corr, m.erro, e[23:0], w[23:0], m.wv};
  endfunction
  function automatic logic [53:0] obs_a();
    return {state_a, locked_a, corr_a, erro_a, err_a, werr_a, wv_a};
  endfunction
  function automatic logic [53:0] obs_b();
    return {state_b, locked_b, corr_b, erro_b, 20'd0, err_b, 20'd0, werr_b, wv_b};
  endfunction

  task automatic tx_sym(output bit [1:0] s);
    for (int k = 1; k >= 0; k--) begin
      s[k] = tx[20] ^ tx[21];
      tx = {tx[20:0], s[k]};
    end
  endtask

  // Drive one cycle of stimulus and advance both models; leaves time at edge+1
  task automatic step(input bit ena, input bit clr, input bit [1:0] cor);
    bit [1:0] s;
    sym_clk_ena = ena; clear_counts = clr;
    if (ena) begin tx_sym(s); slice_in = s ^ cor; end
    else slice_in = 2'($urandom);
    @(posedge clk);
    if (ena) begin
      mdl_step(ma, 16, 8, 100, 24, clr, slice_in);
      mdl_step(mb, 16, 255, 100, 4, clr, slice_in);
    end else begin
      ma.corr = 0; ma.erro = 0; ma.wv = 0;
      mb.corr = 0; mb.erro = 0; mb.wv = 0;
    end
    #1;
  endtask

  task automatic test_reset(input string tag);
    sym_clk_ena = 0; clear_counts = 0;
    @(posedge clk); #3 reset_n = 0; ma = mdl_zero(); mb = mdl_zero(); #1;
    total++; if (obs_a() !== 54'd0) begin bad++; $display("FAIL reset_a_%s got=%h want=0", tag, obs_a()); end
    total++; if (obs_b() !== 54'd0) begin bad++; $display("FAIL reset_b_%s got=%h want=0", tag, obs_b()); end
    @(posedge clk); #1 reset_n = 1;
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 47; i++) begin
      step(1, 0, 0);
      total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL lock_a i=%0d got=%h want=%h", i, obs_a(), exp_v(ma)); end
      total++; if (obs_b() !== exp_v(mb)) begin bad++; $display("FAIL lock_b i=%0d got=%h want=%h", i, obs_b(), exp_v(mb)); end
      if (i == 26) begin
        total++; if ({locked_a, locked_b} !== 2'b00) begin bad++; $display("FAIL lock_early got=%b want=00", {locked_a, locked_b}); end
      end
      if (i == 27) begin
        total++; if ({locked_a, locked_b} !== 2'b11) begin bad++; $display("FAIL lock_at27 got=%b want=11", {locked_a, locked_b}); end
      end
      if (i > 27) begin
        total++; if ({corr_a, erro_a} !== 2'b10) begin bad++; $display("FAIL lock_correct i=%0d got=%b want=10", i, {corr_a, erro_a}); end
      end
    end
  endtask

  task automatic test_single_error();
    step(1, 1, 0);
    step(1, 0, 2'b01);
    total++; if ({erro_a, corr_a, locked_a, err_a} !== {3'b101, 24'd1}) begin bad++; $display("FAIL single_err got=%b/%0d want=101/1", {erro_a, corr_a, locked_a}, err_a); end
    total++; if (obs_b() !== exp_v(mb)) begin bad++; $display("FAIL single_err_b got=%h want=%h", obs_b(), exp_v(mb)); end
    step(1, 0, 0);
    total++; if ({corr_a, erro_a, err_a} !== {2'b10, 24'd1}) begin bad++; $display("FAIL no_propagate got=%b/%0d want=10/1", {corr_a, erro_a}, err_a); end
  endtask

  task automatic test_loss();
    int n = 0;
    step(1, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 2'($urandom_range(1, 3)));
      n += int'(erro_a);
      total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL loss_a i=%0d got=%h want=%h", i, obs_a(), exp_v(ma)); end
    end
    total++; if (n !== 8) begin bad++; $display("FAIL loss_pulses got=%0d want=8", n); end
    total++; if ({state_a, locked_b} !== 3'b001) begin bad++; $display("FAIL loss_state got=%0d/%b want=0/1", state_a, locked_b); end
    for (int i = 1; i <= 27; i++) begin
      step(1, 0, 0);
      total++; if (obs_b() !== exp_v(mb)) begin bad++; $display("FAIL relock_b i=%0d got=%h want=%h", i, obs_b(), exp_v(mb)); end
      if (i == 26 || i == 27) begin
        total++; if (locked_a !== (i == 27)) begin bad++; $display("FAIL relock i=%0d got=%b want=%b", i, locked_a, i == 27); end
      end
    end
  endtask

  task automatic test_window();
    int p0 = $urandom_range(1, 33), p1 = $urandom_range(34, 66), p2 = $urandom_range(67, 100);
    int nv = 0;
    step(1, 1, 0);
    for (int i = 1; i <= 100; i++) begin
      step(1, 0, (i == p0 || i == p1 || i == p2) ? 2'b10 : 2'b00);
      nv += int'(wv_a);
      total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL window_a i=%0d got=%h want=%h", i, obs_a(), exp_v(ma)); end
    end
    total++; if ({nv, wv_a, werr_a, err_a} !== {32'd1, 1'b1, 24'd3, 24'd0}) begin bad++; $display("FAIL window_end got=nv%0d wv%b werr%0d err%0d want=1/1/3/0", nv, wv_a, werr_a, err_a); end
    total++; if ({wv_b, werr_b, err_b} !== {1'b1, 4'd3, 4'd0}) begin bad++; $display("FAIL window_end_b got=%b/%0d/%0d want=1/3/0", wv_b, werr_b, err_b); end
  endtask

  task automatic test_saturate();
    step(1, 1, 0);
    for (int i = 1; i <= 100; i++) begin
      step(1, 0, (i % 5 == 1) ? 2'b01 : 2'b00);
      total++; if (obs_b() !== exp_v(mb)) begin bad++; $display("FAIL sat_b i=%0d got=%h want=%h", i, obs_b(), exp_v(mb)); end
      if (i == 99) begin
        total++; if ({err_b, err_a} !== {4'd15, 24'd20}) begin bad++; $display("FAIL sat_count got=%0d/%0d want=15/20", err_b, err_a); end
      end
    end
    total++; if ({wv_b, werr_b, wv_a, werr_a} !== {1'b1, 4'd15, 1'b1, 24'd20}) begin bad++; $display("FAIL sat_window got=%0d/%0d want=15/20", werr_b, werr_a); end
  endtask

  task automatic test_clear_window_end();
    step(1, 1, 0);
    for (int i = 1; i <= 99; i++) step(1, 0, 0);
    step(1, 1, 2'b01);
    total++; if ({wv_a, wv_b, err_a, err_b} !== 30'd0) begin bad++; $display("FAIL clr_wend got=wv%b%b err%0d/%0d want=00/0/0", wv_a, wv_b, err_a, err_b); end
    total++; if ({werr_a, werr_b, erro_a} !== {24'd20, 4'd15, 1'b1}) begin bad++; $display("FAIL clr_wend_hold got=%0d/%0d/%b want=20/15/1", werr_a, werr_b, erro_a); end
    total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL clr_wend_a got=%h want=%h", obs_a(), exp_v(ma)); end
  endtask

  task automatic test_verify_corrupt();
    for (int i = 1; i <= 12; i++) step(1, 0, 0);
    total++; if ({state_a, state_b} !== 4'b0101) begin bad++; $display("FAIL verify_in got=%0d/%0d want=1/1", state_a, state_b); end
    step(1, 0, 2'($urandom_range(1, 3)));
    total++; if ({state_a, locked_a, state_b, locked_b} !== 6'd0) begin bad++; $display("FAIL verify_drop got=%0d/%0d want=0/0", state_a, state_b); end
    for (int i = 1; i <= 27; i++) begin
      step(1, 0, 0);
      total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL verify_relock i=%0d got=%h want=%h", i, obs_a(), exp_v(ma)); end
    end
    total++; if ({locked_a, locked_b} !== 2'b11) begin bad++; $display("FAIL verify_relock_end got=%b want=11", {locked_a, locked_b}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0,
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      total++; if (obs_a() !== exp_v(ma)) begin bad++; $display("FAIL rand_a i=%0d got=%h want=%h", i, obs_a(), exp_v(ma)); end
      total++; if (obs_b() !== exp_v(mb)) begin bad++; $display("FAIL rand_b i=%0d got=%h want=%h", i, obs_b(), exp_v(mb)); end
    end
  endtask

  initial begin
    clk = 0; reset_n = 1; sym_clk_ena = 0; clear_counts = 0; slice_in = 0;
    total = 0; bad = 0;
    tx = 22'($urandom_range(1, 22'h3FFFFF));
    ma = mdl_zero(); mb = mdl_zero();
    test_reset("init");
    test_lock();
    test_single_error();
    test_loss();
    test_window();
    test_saturate();
    test_clear_window_end();
    test_reset("locked");
    test_verify_corrupt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
